regfile_checker: RTL and testbench
==================================

# regfile_checker

Synthesizable self-check sequencer that wraps the pipelined RISC-V core for on-chip or FPGA regression. It drives the core's reset, lets the program run for a fixed cycle budget, then scans a parametrised list of architectural registers through a register-file debug read port. Each register is compared against a masked expected value, and the block reports pass/fail, a mismatch count and the first failing entry. It sits beside `pl_riscv_cpu` at the top level and replaces hand-written per-test register checks with a table-driven, N-entry checker.

## Interface

Parameters:
- `NUM_CHECKS`, 11, number of expected-value table entries (1..31).
- `RESET_CYCLES`, 2, cycles the core reset is held after `start` (≥1).
- `RUN_CYCLES`, 50, cycles the core runs before checking begins (≥1).
- `XLEN`, 32, register data width.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; returns the block to IDLE.
- `start` in 1: one-cycle request to begin a test; honoured only in IDLE or DONE.
- `cpu_reset` out 1: drives the core's `reset`.
- `chk_idx` out 5: current table index, 0..NUM_CHECKS-1.
- `chk_addr` in 5: register number for `chk_idx`, from the table ROM (combinational).
- `chk_value` in XLEN: expected value for `chk_idx`.
- `chk_mask` in XLEN: per-bit compare enable; 0 bits are don't-care.
- `rf_raddr` out 5: register-file debug read address; equals `chk_addr` in CHECK.
- `rf_rdata` in XLEN: combinational register-file debug read data.
- `busy` out 1: high in RESET_CPU, RUN, CHECK and MEMCHK.
- `done` out 1: high in DONE.
- `pass` out 1: valid while `done`; 1 iff `fail_count == 0`.
- `fail_count` out 6: number of mismatching entries, saturating at 63.
- `first_fail_idx` out 5: table index of the first mismatch; 31 if none.

## Operation

States are IDLE, RESET_CPU, RUN, CHECK, MEMCHK (macro only) and DONE.
- **IDLE:** `cpu_reset`=1. On `start`, go to RESET_CPU, clear `fail_count`, and set `first_fail_idx`=31.
- **RESET_CPU:** `cpu_reset`=1. Count RESET_CYCLES cycles, then go to RUN.
- **RUN:** `cpu_reset`=0. Count RUN_CYCLES cycles, then go to CHECK with `chk_idx`=0.
- **CHECK:** one entry per cycle.
  - Mismatch is defined as `((rf_rdata ^ chk_value) & chk_mask) != 0`.
  - On a mismatch, increment `fail_count` (saturating at 63).
  - On the first mismatch only, capture `chk_idx` into `first_fail_idx`.
  - After index NUM_CHECKS-1, go to MEMCHK if enabled, otherwise DONE.
- **DONE:** `cpu_reset`=0, so the core keeps running. Results are held. `start` restarts the sequence exactly as from IDLE.

Further rules:
- `start` received while busy is ignored.
- `chk_addr`=0 is compared like any other entry; x0 must read 0.
- Entry with `chk_mask`=0 always passes; use it for registers that are flushed or undefined.
- Counters are sized `$clog2(max(RESET_CYCLES,RUN_CYCLES,NUM_CHECKS)+1)`.

## Timing

Reset values:
- state IDLE, `cpu_reset`=1, `busy`=0, `done`=0, `pass`=0.
- `fail_count`=0, `first_fail_idx`=31, `chk_idx`=0, `rf_raddr`=0.

Timing rules:
- All outputs are registered except `rf_raddr`, which is combinational from state and `chk_addr`.
- `start` sampled high at edge T puts `busy`=1 and `cpu_reset`=1 from T+1.
- `cpu_reset` falls at T+1+RESET_CYCLES.
- CHECK begins at T+1+RESET_CYCLES+RUN_CYCLES.
- `done` rises NUM_CHECKS cycles after CHECK begins, plus 1 with the macro.
- Comparison uses `rf_rdata` in the same cycle `chk_idx` is presented; the register-file read path must be combinational.
- Async `reset` mid-test: return to IDLE immediately, `cpu_reset`=1, results cleared; no partial result is reported.

## Configuration

- Macro `REGFILE_CHECKER_MEMCHK_EN` defined adds the following:
  - Ports `mem_addr` out 32, `mem_rdata` in XLEN, `mem_exp_addr` in 32, `mem_exp_value` in XLEN.
  - A MEMCHK state of one cycle drives `mem_addr`=`mem_exp_addr` and compares `mem_rdata` against `mem_exp_value` with a full mask.
  - A memory mismatch increments `fail_count` and sets `first_fail_idx`=30 if no prior failure was recorded.
- Macro undefined: these ports and the MEMCHK state are absent, and CHECK goes directly to DONE.

## Test plan

- **Default run:** NUM_CHECKS=11 with the hazard program table (x1=100, x5=20, x6 mask 0, x7=4096, x11=20). After `start`, `done` at cycle 1+2+50+11. Require `pass`=1, `fail_count`=0, `first_fail_idx`=31.
- **Corrupt two entries:** expected x3=101 (idx 2) and x8=99 (idx 7). Require `fail_count`=2 and `first_fail_idx`=2.
- **Mask check:** x9 expected 0xFFFF_FF63 with mask 0x0000_00FF, actual 99. Require pass.
- **Start while busy:** assert `start` during RUN. Require `done` timing unchanged.
- **Reset mid-test:** assert `reset` during CHECK. Require IDLE and `cpu_reset`=1 in the same cycle, `fail_count`=0. A new `start` completes normally.
- **Memory check (macro on):** `mem_exp_addr`=4096, `mem_exp_value`=100. Require pass. Changing `mem_exp_value` to 101 gives `fail_count`=1 and `first_fail_idx`=30.

Source files
------------

// File: rtl/regfile_checker_if.sv
// Bus bundle between regfile_checker and its environment (core, table ROM, register file).
// With REGFILE_CHECKER_MEMCHK_EN defined it also carries the memory-check port group.
interface regfile_checker_if #(
   parameter int unsigned XLEN = 32
);
   logic            start;
   logic            cpu_reset;
   logic [4:0]      chk_idx;
   logic [4:0]      chk_addr;
   logic [XLEN-1:0] chk_value;
   logic [XLEN-1:0] chk_mask;
   logic [4:0]      rf_raddr;
   logic [XLEN-1:0] rf_rdata;
   logic            busy;
   logic            done;
   logic            pass;
   logic [5:0]      fail_count;
   logic [4:0]      first_fail_idx;
`ifdef REGFILE_CHECKER_MEMCHK_EN
   logic [31:0]     mem_addr;
   logic [XLEN-1:0] mem_rdata;
   logic [31:0]     mem_exp_addr;
   logic [XLEN-1:0] mem_exp_value;
`endif

   // Checker side
   modport master (
      input  start, chk_addr, chk_value, chk_mask, rf_rdata,
      output cpu_reset, chk_idx, rf_raddr, busy, done, pass, fail_count, first_fail_idx
`ifdef REGFILE_CHECKER_MEMCHK_EN
      , output mem_addr
      , input  mem_rdata, mem_exp_addr, mem_exp_value
`endif
   );

   // Environment side
   modport slave (
      output start, chk_addr, chk_value, chk_mask, rf_rdata,
      input  cpu_reset, chk_idx, rf_raddr, busy, done, pass, fail_count, first_fail_idx
`ifdef REGFILE_CHECKER_MEMCHK_EN
      , input  mem_addr
      , output mem_rdata, mem_exp_addr, mem_exp_value
`endif
   );
endinterface

// File: rtl/regfile_checker.sv
// Self-check sequencer: holds the core in reset, runs it for a fixed budget, then walks a
// table of masked expected register values through the register-file debug port.
// Optional memory-word check enabled by defining REGFILE_CHECKER_MEMCHK_EN.
module regfile_checker #(
   parameter int unsigned NUM_CHECKS   = 11,
   parameter int unsigned RESET_CYCLES = 2,
   parameter int unsigned RUN_CYCLES   = 50,
   parameter int unsigned XLEN         = 32
) (
   input  logic             clk,
   input  logic             reset,
   regfile_checker_if.master bus
);

   localparam int unsigned MAX_RR  = (RESET_CYCLES > RUN_CYCLES) ? RESET_CYCLES : RUN_CYCLES;
   localparam int unsigned CNT_MAX = (MAX_RR > NUM_CHECKS) ? MAX_RR : NUM_CHECKS;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam int unsigned IDX_W   = 5;
   localparam int unsigned FAIL_W  = 6;

   localparam logic [IDX_W-1:0]  NO_FAIL_IDX  = IDX_W'(31);
   localparam logic [IDX_W-1:0]  MEM_FAIL_IDX = IDX_W'(30);
   localparam logic [FAIL_W-1:0] FAIL_SAT     = FAIL_W'(63);
   localparam logic [IDX_W-1:0]  LAST_IDX     = IDX_W'(NUM_CHECKS - 1);
   localparam logic [CNT_W-1:0]  RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0]  RUN_LAST     = CNT_W'(RUN_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RESET_CPU,
      S_RUN,
      S_CHECK,
      S_MEMCHK,
      S_DONE
   } state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [IDX_W-1:0]   chk_idx_r, idx_nxt;
   logic [FAIL_W-1:0]  fail_r, fail_nxt;
   logic [IDX_W-1:0]   first_r, first_nxt;
   logic               cpu_reset_r, busy_r, done_r, pass_r;
   logic               rec_en;
   logic [IDX_W-1:0]   rec_idx;
   logic               rf_mismatch_c;
`ifdef REGFILE_CHECKER_MEMCHK_EN
   logic [31:0]        mem_addr_r;
   logic               mem_mismatch_c;
`endif

   // Masked compare of the presented table entry against the live register value
   assign rf_mismatch_c = |((bus.rf_rdata ^ bus.chk_value) & bus.chk_mask);
`ifdef REGFILE_CHECKER_MEMCHK_EN
   assign mem_mismatch_c = (bus.mem_rdata != bus.mem_exp_value);
`endif

   // Next-state, counters and result bookkeeping
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = chk_idx_r;
      fail_nxt  = fail_r;
      first_nxt = first_r;
      rec_en    = 1'b0;
      rec_idx   = chk_idx_r;

      case (state)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               state_nxt = S_RESET_CPU;
               cnt_nxt   = '0;
               idx_nxt   = '0;
               fail_nxt  = '0;
               first_nxt = NO_FAIL_IDX;
            end
         end
         S_RESET_CPU: begin
            if (cnt == RESET_LAST) begin
               state_nxt = S_RUN;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         S_RUN: begin
            if (cnt == RUN_LAST) begin
               state_nxt = S_CHECK;
               cnt_nxt   = '0;
               idx_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         S_CHECK: begin
            rec_en  = rf_mismatch_c;
            rec_idx = chk_idx_r;
            if (chk_idx_r == LAST_IDX) begin
`ifdef REGFILE_CHECKER_MEMCHK_EN
               state_nxt = S_MEMCHK;
`else
               state_nxt = S_DONE;
`endif
            end else begin
               idx_nxt = chk_idx_r + IDX_W'(1);
            end
         end
`ifdef REGFILE_CHECKER_MEMCHK_EN
         S_MEMCHK: begin
            rec_en    = mem_mismatch_c;
            rec_idx   = MEM_FAIL_IDX;
            state_nxt = S_DONE;
         end
`endif
         default: state_nxt = S_IDLE;
      endcase

      // Only one mismatch can be recorded per cycle, so the registered count tells "first"
      if (rec_en) begin
         if (fail_r != FAIL_SAT) fail_nxt = fail_r + FAIL_W'(1);
         if (fail_r == '0)       first_nxt = rec_idx;
      end
   end

   // State, datapath and registered outputs decoded from the next state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         cnt         <= '0;
         chk_idx_r   <= '0;
         fail_r      <= '0;
         first_r     <= NO_FAIL_IDX;
         cpu_reset_r <= 1'b1;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         pass_r      <= 1'b0;
`ifdef REGFILE_CHECKER_MEMCHK_EN
         mem_addr_r  <= '0;
`endif
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         chk_idx_r   <= idx_nxt;
         fail_r      <= fail_nxt;
         first_r     <= first_nxt;
         cpu_reset_r <= (state_nxt == S_IDLE) || (state_nxt == S_RESET_CPU);
         busy_r      <= (state_nxt == S_RESET_CPU) || (state_nxt == S_RUN) ||
                        (state_nxt == S_CHECK)     || (state_nxt == S_MEMCHK);
         done_r      <= (state_nxt == S_DONE);
         pass_r      <= (state_nxt == S_DONE) && (fail_nxt == '0);
`ifdef REGFILE_CHECKER_MEMCHK_EN
         mem_addr_r  <= (state_nxt == S_MEMCHK) ? bus.mem_exp_addr : 32'd0;
`endif
      end
   end

   // Debug read address follows the table only while scanning
   assign bus.rf_raddr       = (state == S_CHECK) ? bus.chk_addr : '0;
   assign bus.cpu_reset      = cpu_reset_r;
   assign bus.chk_idx        = chk_idx_r;
   assign bus.busy           = busy_r;
   assign bus.done           = done_r;
   assign bus.pass           = pass_r;
   assign bus.fail_count     = fail_r;
   assign bus.first_fail_idx = first_r;
`ifdef REGFILE_CHECKER_MEMCHK_EN
   assign bus.mem_addr       = mem_addr_r;
`endif

endmodule

// File: tb/tb_regfile_checker.sv
// Scoreboard bench for regfile_checker: a stimulus process pushes the expected result of
// each run (from a table/register-array reference model), a monitor pops on each done rise.
module tb_regfile_checker;

   localparam int unsigned XLEN         = 32;
   localparam int unsigned NUM_CHECKS   = 11;
   localparam int unsigned RESET_CYCLES = 2;
   localparam int unsigned RUN_CYCLES   = 50;
`ifdef REGFILE_CHECKER_MEMCHK_EN
   localparam int unsigned MEM_EXTRA    = 1;
`else
   localparam int unsigned MEM_EXTRA    = 0;
`endif
   // Cycles from the cycle start is driven to the first cycle done is visible
   localparam int unsigned DONE_LAT = 1 + RESET_CYCLES + RUN_CYCLES + NUM_CHECKS + MEM_EXTRA;

   typedef struct {
      string        name;
      int unsigned  done_cyc;
      int unsigned  fall_cyc;
      logic         pass;
      logic [5:0]   fails;
      logic [4:0]   first;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   regfile_checker_if #(.XLEN(XLEN)) bus ();

   regfile_checker #(
      .NUM_CHECKS  (NUM_CHECKS),
      .RESET_CYCLES(RESET_CYCLES),
      .RUN_CYCLES  (RUN_CYCLES),
      .XLEN        (XLEN)
   ) u_dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference state: architectural registers and the expected-value table
   logic [XLEN-1:0] rf [32];
   logic [4:0]      tbl_addr [NUM_CHECKS];
   logic [XLEN-1:0] tbl_val  [NUM_CHECKS];
   logic [XLEN-1:0] tbl_mask [NUM_CHECKS];

   function automatic logic [XLEN-1:0] rd(input logic [4:0] a);
      return (a == 5'd0) ? '0 : rf[a];
   endfunction

   assign bus.chk_addr  = (bus.chk_idx < 5'(NUM_CHECKS)) ? tbl_addr[bus.chk_idx] : 5'd0;
   assign bus.chk_value = (bus.chk_idx < 5'(NUM_CHECKS)) ? tbl_val[bus.chk_idx]  : '0;
   assign bus.chk_mask  = (bus.chk_idx < 5'(NUM_CHECKS)) ? tbl_mask[bus.chk_idx] : '0;
   assign bus.rf_rdata  = rd(bus.rf_raddr);

`ifdef REGFILE_CHECKER_MEMCHK_EN
   logic [XLEN-1:0] mem_exp_value;
   function automatic logic [XLEN-1:0] mem_rd(input logic [31:0] a);
      return (a == 32'd4096) ? XLEN'(100) : '0;
   endfunction
   assign bus.mem_exp_addr  = 32'd4096;
   assign bus.mem_exp_value = mem_exp_value;
   assign bus.mem_rdata     = mem_rd(bus.mem_addr);
`endif

   int   checks     = 0;
   int   failures   = 0;
   int   done_count = 0;
   exp_t exp_q[$];

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // Expected result straight from the table rules
   task automatic model(output logic p, output logic [5:0] f, output logic [4:0] first);
      int nf = 0;
      first = 5'd31;
      for (int i = 0; i < int'(NUM_CHECKS); i++) begin
         if (((rd(tbl_addr[i]) ^ tbl_val[i]) & tbl_mask[i]) != '0) begin
            if (nf == 0) first = 5'(i);
            nf++;
         end
      end
`ifdef REGFILE_CHECKER_MEMCHK_EN
      if (mem_rd(32'd4096) != mem_exp_value) begin
         if (nf == 0) first = 5'd30;
         nf++;
      end
`endif
      f = (nf > 63) ? 6'd63 : 6'(nf);
      p = (nf == 0);
   endtask

   // Register state left by the hazard test program, and its check table
   task automatic set_hazard_table();
      for (int i = 1; i < 32; i++) rf[i] = $urandom;
      rf[0] = '0;
      rf[1] = 100; rf[2] = 50;   rf[3] = 100; rf[4] = 150; rf[5]  = 20;
      rf[7] = 4096; rf[8] = 100; rf[9] = 99;  rf[11] = 20;
      tbl_addr = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd0, 5'd11};
      tbl_val  = '{32'd100, 32'd50, 32'd100, 32'd150, 32'd20, 32'd0, 32'd4096, 32'd100,
                   32'hFFFF_FF63, 32'd0, 32'd20};
      tbl_mask = '{'1, '1, '1, '1, '1, 32'd0, '1, '1, 32'h0000_00FF, '1, '1};
`ifdef REGFILE_CHECKER_MEMCHK_EN
      mem_exp_value = 100;
`endif
   endtask

   task automatic set_random_table();
      for (int i = 1; i < 32; i++) rf[i] = $urandom;
      for (int i = 0; i < int'(NUM_CHECKS); i++) begin
         int unsigned mk;
         tbl_addr[i] = 5'($urandom_range(0, 31));
         mk = $urandom_range(0, 3);
         tbl_mask[i] = (mk == 0) ? '0 : (mk == 1) ? '1 : XLEN'($urandom);
         tbl_val[i]  = rd(tbl_addr[i]);
         if ($urandom_range(0, 2) == 0) tbl_val[i] ^= (XLEN'(1) << $urandom_range(0, XLEN - 1));
      end
`ifdef REGFILE_CHECKER_MEMCHK_EN
      mem_exp_value = ($urandom_range(0, 1) == 0) ? XLEN'(100) : XLEN'(101);
`endif
   endtask

   // Issue one test, optionally poking start again during RUN, and wait for its result
   task automatic run_test(input string name, input bit poke);
      exp_t e;
      int   base;
      model(e.pass, e.fails, e.first);
      e.name     = name;
      e.done_cyc = cyc + DONE_LAT;
      e.fall_cyc = cyc + 1 + RESET_CYCLES;
      exp_q.push_back(e);
      base = done_count;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      if (poke) begin
         repeat (RESET_CYCLES + 10) @(negedge clk);
         bus.start = 1'b1;
         @(negedge clk);
         bus.start = 1'b0;
      end
      for (int i = 0; i < int'(DONE_LAT) + 20 && done_count == base; i++) @(negedge clk);
      check({name, "_done_seen"}, longint'(done_count), longint'(base + 1));
      @(negedge clk);
   endtask

   // Monitor: track core-reset release and score each completed run
   logic prev_done = 1'b0;
   logic prev_cpu_reset = 1'b1;
   int unsigned fall_cyc = 0;
   exp_t me;
   always @(negedge clk) begin
      if (reset) begin
         prev_done      = 1'b0;
         prev_cpu_reset = 1'b1;
      end else begin
         if (prev_cpu_reset && !bus.cpu_reset) fall_cyc = cyc;
         if (bus.done && !prev_done) begin
            check("sb_nonempty", longint'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               me = exp_q.pop_front();
               check({me.name, "_done_cycle"},     longint'(cyc),                longint'(me.done_cyc));
               check({me.name, "_cpu_reset_fall"}, longint'(fall_cyc),           longint'(me.fall_cyc));
               check({me.name, "_pass"},           longint'(bus.pass),           longint'(me.pass));
               check({me.name, "_fail_count"},     longint'(bus.fail_count),     longint'(me.fails));
               check({me.name, "_first_fail_idx"}, longint'(bus.first_fail_idx), longint'(me.first));
            end
            done_count++;
         end
         prev_done      = bus.done;
         prev_cpu_reset = bus.cpu_reset;
      end
   end

   initial begin
      reset     = 1'b1;
      bus.start = 1'b0;
      set_hazard_table();
      repeat (2) @(negedge clk);
      check("rst_cpu_reset",  longint'(bus.cpu_reset),      1);
      check("rst_busy",       longint'(bus.busy),           0);
      check("rst_done",       longint'(bus.done),           0);
      check("rst_pass",       longint'(bus.pass),           0);
      check("rst_fail_count", longint'(bus.fail_count),     0);
      check("rst_first_idx",  longint'(bus.first_fail_idx), 31);
      check("rst_chk_idx",    longint'(bus.chk_idx),        0);
      check("rst_rf_raddr",   longint'(bus.rf_raddr),       0);
      reset = 1'b0;
      @(negedge clk);

      run_test("default", 1'b0);

      tbl_val[2] = 101;
      tbl_val[7] = 99;
      run_test("corrupt", 1'b0);

      set_hazard_table();
      run_test("busy_start", 1'b1);

      // Reset during CHECK after two failing entries have been scored
      set_hazard_table();
      tbl_val[0] = 1;
      tbl_val[1] = 2;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (RESET_CYCLES + RUN_CYCLES + 4) @(negedge clk);
      check("mid_fail_count", longint'(bus.fail_count), 2);
      check("mid_busy",       longint'(bus.busy),       1);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_cpu_reset",  longint'(bus.cpu_reset),      1);
      check("mid_rst_busy",       longint'(bus.busy),           0);
      check("mid_rst_done",       longint'(bus.done),           0);
      check("mid_rst_fail_count", longint'(bus.fail_count),     0);
      check("mid_rst_first_idx",  longint'(bus.first_fail_idx), 31);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      set_hazard_table();
      run_test("after_reset", 1'b0);

`ifdef REGFILE_CHECKER_MEMCHK_EN
      mem_exp_value = 101;
      run_test("mem_bad", 1'b0);
`endif

      for (int n = 0; n < 8; n++) begin
         set_random_table();
         run_test($sformatf("rand%0d", n), ($urandom_range(0, 3) == 0));
      end

      check("sb_drained", longint'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
